// File: rtl/fread_sched.sv
// Job-level scheduler in front of spi_dev_fread: round-robin job arbitration, chunk splitting, byte forwarding.
// Optional idle-byte watchdog enabled by defining FREAD_SCHED_TIMEOUT_EN.
module fread_sched #(
    parameter int N_REQ          = 2,
    parameter int CHUNK_MAX      = 2048,
    parameter int TIMEOUT_CYCLES = 1 << 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      job_valid,
    output logic [N_REQ-1:0]      job_ready,
    input  logic [32*N_REQ-1:0]   job_file_id,
    input  logic [32*N_REQ-1:0]   job_offset,
    input  logic [24*N_REQ-1:0]   job_len,
    output logic [N_REQ-1:0]      job_done,
    output logic [N_REQ-1:0]      job_err,
    output logic [31:0]           req_file_id,
    output logic [31:0]           req_offset,
    output logic [10:0]           req_len,
    output logic                  req_valid,
    input  logic                  req_ready,
    input  logic [7:0]            resp_data,
    input  logic                  resp_valid,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    output logic [1:0]            out_owner,
    output logic                  busy
);

    if (N_REQ < 1 || N_REQ > 4 || CHUNK_MAX < 1 || CHUNK_MAX > 2048 ||
        (CHUNK_MAX & (CHUNK_MAX - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("fread_sched: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_ARB, S_REQ, S_WAIT, S_DONE, S_ERR
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  rr;
    logic [1:0]  owner;
    logic [1:0]  grant;
    logic        grant_hit;
    logic [23:0] remaining;
    logic [23:0] rem_after;
    logic [11:0] count;
    logic [11:0] chunk;
    logic        chunk_last;
    logic        timeout;

    function automatic logic [11:0] clip(input logic [23:0] n);
        return (n >= 24'(CHUNK_MAX)) ? 12'(CHUNK_MAX) : n[11:0];
    endfunction

    // req_len already holds chunk-1 for the chunk in flight.
    assign chunk      = 12'(req_len) + 12'd1;
    assign chunk_last = resp_valid && (count + 12'd1 == chunk);
    assign rem_after  = remaining - 24'(chunk);
    assign busy       = (state != S_IDLE);

    // First valid requester at or after the round-robin pointer, wrapping.
    always_comb begin
        grant     = '0;
        grant_hit = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!grant_hit && job_valid[(int'(rr) + i) % N_REQ]) begin
                grant_hit = 1'b1;
                grant     = 2'((int'(rr) + i) % N_REQ);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt = state;
        job_ready = '0;
        req_valid = 1'b0;
        case (state)
            S_IDLE: if (|job_valid) state_nxt = S_ARB;
            S_ARB: begin
                if (grant_hit) begin
                    job_ready = N_REQ'(1) << grant;
                    state_nxt = (job_len[24*grant +: 24] == '0) ? S_DONE : S_REQ;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_REQ: begin
                req_valid = 1'b1;
                if (req_ready) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (chunk_last)   state_nxt = (rem_after == '0) ? S_DONE : S_REQ;
                else if (timeout) state_nxt = S_ERR;
            end
            S_DONE:  state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr          <= '0;
            owner       <= '0;
            remaining   <= '0;
            count       <= '0;
            req_file_id <= '0;
            req_offset  <= '0;
            req_len     <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_owner   <= '0;
            job_done    <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every read sees the pre-edge value.
            out_valid <= 1'b0;
            job_done  <= '0;
            case (state)
                S_ARB: begin
                    if (grant_hit) begin
                        owner       <= grant;
                        rr          <= 2'((int'(grant) + 1) % N_REQ);
                        req_file_id <= job_file_id[32*grant +: 32];
                        req_offset  <= job_offset[32*grant +: 32];
                        remaining   <= job_len[24*grant +: 24];
                        req_len     <= 11'(clip(job_len[24*grant +: 24]) - 12'd1);
                    end
                end
                S_REQ: if (req_ready) count <= '0;
                S_WAIT: begin
                    if (resp_valid) begin
                        out_data  <= resp_data;
                        out_valid <= 1'b1;
                        out_owner <= owner;
                        count     <= count + 12'd1;
                        if (chunk_last) begin
                            req_offset <= req_offset + 32'(chunk);
                            remaining  <= rem_after;
                            req_len    <= 11'(clip(rem_after) - 12'd1);
                        end
                    end
                end
                S_DONE:  job_done <= N_REQ'(1) << owner;
                default: ;
            endcase
        end
    end

`ifdef FREAD_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;

    // Counts consecutive byte-less cycles in WAIT; any other state holds it at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt  <= '0;
            job_err <= '0;
        end else begin
            job_err <= (state == S_ERR) ? (N_REQ'(1) << owner) : '0;
            if (state != S_WAIT || resp_valid) wd_cnt <= '0;
            else                               wd_cnt <= wd_cnt + 1'b1;
        end
    end

    assign timeout = (state == S_WAIT) && !resp_valid && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
    assign job_err = '0;
`endif

endmodule
